// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between the MEM stage and the data memory load/store unit.
// master drives requests and consumes responses; slave is the memory side.
interface data_mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        rsp_is_st;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_is_st
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_is_st
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-addressable RV32I data memory with load/store unit and a fixed-latency response pipe.
// Faulting accesses (misaligned, out of range, illegal funct3) never write and return zero data.
module data_mem_lsu #(
  parameter int unsigned DEPTH_WORDS  = 256,
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned INIT_PATTERN = 1
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_lsu_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        fault;
    logic        is_st;
  } stage_t;

  logic [31:0]   mem_rd [DEPTH_WORDS];
  logic          accept;
  logic [AW-1:0] idx;
  logic          oor;
  logic          legal;
  logic          misal;
  logic          fault;
  logic [3:0]    be;
  logic          wr_en;
  logic [31:0]   wdata_rep;
  logic [31:0]   shifted;
  logic [31:0]   ld_data;
  stage_t        in_stage;

  stage_t [READ_LAT-1:0] pipe_q;
  stage_t [READ_LAT:0]   chain;

  assign bus.req_ready = !rst;

  always_comb begin
    accept = bus.req_valid && bus.req_ready;
    idx    = bus.req_addr[AW+1:2];
    oor    = |bus.req_addr[31:AW+2];

    unique case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !bus.req_we;
      default:                legal = 1'b0;
    endcase

    misal = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
            ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    fault = !legal || misal || oor;

    unique case (bus.req_funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << bus.req_addr[1:0];
        wdata_rep = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << bus.req_addr[1:0];
        wdata_rep = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = bus.req_wdata;
      end
    endcase

    wr_en = accept && bus.req_we && !fault;

    // Load path reads the pre-edge contents, so a store from the previous edge is visible.
    shifted = mem_rd[idx] >> {bus.req_addr[1:0], 3'b000};
    unique case (bus.req_funct3)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  ld_data = shifted;
      3'b100:  ld_data = {24'h0, shifted[7:0]};
      3'b101:  ld_data = {16'h0, shifted[15:0]};
      default: ld_data = 32'h0;
    endcase
    if (fault || bus.req_we) ld_data = 32'h0;

    in_stage.valid = accept;
    in_stage.rdata = accept ? ld_data : 32'h0;
    in_stage.fault = accept && fault;
    in_stage.is_st = accept && bus.req_we;
  end

  // One register per word so each can carry its own power-up value; contents survive reset.
  for (genvar gi = 0; gi < DEPTH_WORDS; gi++) begin : g_word
    logic [31:0] word_q = (INIT_PATTERN == 1) ? 32'(gi) : 32'h0;

    always_ff @(posedge clk) begin
      if (wr_en && (idx == AW'(gi))) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) word_q[8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end

    assign mem_rd[gi] = word_q;
  end

  assign chain = {pipe_q, in_stage};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= chain[READ_LAT-1:0];
    end
  end

  assign bus.rsp_valid = pipe_q[READ_LAT-1].valid;
  assign bus.rsp_rdata = pipe_q[READ_LAT-1].rdata;
  assign bus.rsp_fault = pipe_q[READ_LAT-1].fault;
  assign bus.rsp_is_st = pipe_q[READ_LAT-1].is_st;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: one instance at READ_LAT=1, one at READ_LAT=3.
// Responses are packed as {valid, fault, is_st, rdata} and compared against hand-computed values.
module tb_data_mem_lsu;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  int   checks   = 0;
  int   failures = 0;

  data_mem_lsu_if bus1 ();
  data_mem_lsu_if bus3 ();

  data_mem_lsu #(.DEPTH_WORDS(256), .READ_LAT(1), .INIT_PATTERN(1)) u_lat1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  data_mem_lsu #(.DEPTH_WORDS(256), .READ_LAT(3), .INIT_PATTERN(1)) u_lat3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

  function automatic logic [34:0] rsp1();
    return {bus1.rsp_valid, bus1.rsp_fault, bus1.rsp_is_st, bus1.rsp_rdata};
  endfunction

  function automatic logic [34:0] rsp3();
    return {bus3.rsp_valid, bus3.rsp_fault, bus3.rsp_is_st, bus3.rsp_rdata};
  endfunction

  // Called at a negedge; returns at the next negedge with the LAT1 response visible.
  task automatic issue1(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    bus1.req_valid  = 1'b1;
    bus1.req_we     = we;
    bus1.req_funct3 = f3;
    bus1.req_addr   = addr;
    bus1.req_wdata  = wdata;
    @(negedge clk);
    bus1.req_valid  = 1'b0;
  endtask

  task automatic test_reset();
    logic [34:0] exp;
    #2;
    checks++;
    if (bus1.req_ready !== 1'b0 || bus3.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got %b/%b want 0/0", bus1.req_ready, bus3.req_ready);
    end
    exp = 35'h0;
    checks++;
    if (rsp1() !== exp || rsp3() !== exp) begin
      failures++;
      $display("FAIL reset_rsp got %h/%h want %h", rsp1(), rsp3(), exp);
    end
    @(negedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    rst3 = 1'b0;
    #1;
    checks++;
    if (bus1.req_ready !== 1'b1 || bus3.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_ready got %b/%b want 1/1", bus1.req_ready, bus3.req_ready);
    end
    @(negedge clk);
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL idle_rsp got %h want %h", rsp1(), exp);
    end
  endtask

  task automatic test_lw();
    logic [34:0] exp;
    issue1(1'b0, 3'b010, 32'h14, 32'h0);
    exp = {3'b100, 32'h0000_0005};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL lw_0x14 got %h want %h", rsp1(), exp);
    end
    @(negedge clk);
    exp = 35'h0;
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL bubble got %h want %h", rsp1(), exp);
    end
  endtask

  task automatic test_byte();
    logic [34:0] exp;
    issue1(1'b1, 3'b000, 32'h21, 32'h0000_00F0);
    exp = {3'b101, 32'h0};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL sb_rsp got %h want %h", rsp1(), exp);
    end
    issue1(1'b0, 3'b010, 32'h20, 32'h0);
    exp = {3'b100, 32'h0000_F008};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL sb_lw got %h want %h", rsp1(), exp);
    end
    issue1(1'b0, 3'b000, 32'h21, 32'h0);
    exp = {3'b100, 32'hFFFF_FFF0};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL lb got %h want %h", rsp1(), exp);
    end
    issue1(1'b0, 3'b100, 32'h21, 32'h0);
    exp = {3'b100, 32'h0000_00F0};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL lbu got %h want %h", rsp1(), exp);
    end
  endtask

  task automatic test_half();
    logic [34:0] exp;
    issue1(1'b1, 3'b001, 32'h0E, 32'h0000_ABCD);
    issue1(1'b0, 3'b010, 32'h0C, 32'h0);
    exp = {3'b100, 32'hABCD_0003};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL sh_lw got %h want %h", rsp1(), exp);
    end
    issue1(1'b0, 3'b001, 32'h0E, 32'h0);
    exp = {3'b100, 32'hFFFF_ABCD};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL lh got %h want %h", rsp1(), exp);
    end
    issue1(1'b0, 3'b101, 32'h0E, 32'h0);
    exp = {3'b100, 32'h0000_ABCD};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL lhu got %h want %h", rsp1(), exp);
    end
  endtask

  task automatic test_faults();
    logic [34:0] exp;
    issue1(1'b0, 3'b010, 32'h22, 32'h0);
    exp = {3'b110, 32'h0};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL lw_misaligned got %h want %h", rsp1(), exp);
    end
    issue1(1'b1, 3'b001, 32'h13, 32'h0000_1234);
    exp = {3'b111, 32'h0};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL sh_misaligned got %h want %h", rsp1(), exp);
    end
    issue1(1'b1, 3'b010, 32'h400, 32'hFFFF_FFFF);
    exp = {3'b111, 32'h0};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL sw_out_of_range got %h want %h", rsp1(), exp);
    end
    issue1(1'b0, 3'b011, 32'h00, 32'h0);
    exp = {3'b110, 32'h0};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL load_f3_011 got %h want %h", rsp1(), exp);
    end
    issue1(1'b1, 3'b100, 32'h20, 32'hFFFF_FFFF);
    exp = {3'b111, 32'h0};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL store_f3_100 got %h want %h", rsp1(), exp);
    end
    issue1(1'b0, 3'b010, 32'h20, 32'h0);
    exp = {3'b100, 32'h0000_F008};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL word8_kept got %h want %h", rsp1(), exp);
    end
    issue1(1'b0, 3'b010, 32'h10, 32'h0);
    exp = {3'b100, 32'h0000_0004};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL word4_kept got %h want %h", rsp1(), exp);
    end
    issue1(1'b0, 3'b010, 32'h00, 32'h0);
    exp = {3'b100, 32'h0000_0000};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL word0_kept got %h want %h", rsp1(), exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [34:0] exp;
    issue1(1'b1, 3'b010, 32'h30, 32'h55AA_1234);
    exp = {3'b101, 32'h0};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL b2b_sw got %h want %h", rsp1(), exp);
    end
    issue1(1'b0, 3'b010, 32'h30, 32'h0);
    exp = {3'b100, 32'h55AA_1234};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL b2b_raw_lw got %h want %h", rsp1(), exp);
    end
    issue1(1'b0, 3'b001, 32'h32, 32'h0);
    exp = {3'b100, 32'h0000_55AA};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL b2b_lh_pos got %h want %h", rsp1(), exp);
    end
    issue1(1'b0, 3'b000, 32'h33, 32'h0);
    exp = {3'b100, 32'h0000_0055};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL b2b_lb_pos got %h want %h", rsp1(), exp);
    end
    issue1(1'b0, 3'b100, 32'h30, 32'h0);
    exp = {3'b100, 32'h0000_0034};
    checks++;
    if (rsp1() !== exp) begin
      failures++;
      $display("FAIL b2b_lbu got %h want %h", rsp1(), exp);
    end
  endtask

  task automatic test_lat3_burst();
    logic [34:0] exp;
    for (int c = 0; c < 10; c++) begin
      bus3.req_valid  = (c < 5);
      bus3.req_we     = 1'b0;
      bus3.req_funct3 = 3'b010;
      bus3.req_addr   = 32'(4 * c);
      @(negedge clk);
      exp = (c >= 2 && c <= 6) ? {3'b100, 32'(c - 2)} : 35'h0;
      checks++;
      if (rsp3() !== exp) begin
        failures++;
        $display("FAIL lat3_burst_c%0d got %h want %h", c, rsp3(), exp);
      end
    end
    bus3.req_valid = 1'b0;
  endtask

  task automatic test_lat3_reset();
    int n;
    bus3.req_valid  = 1'b1;
    bus3.req_we     = 1'b1;
    bus3.req_funct3 = 3'b010;
    bus3.req_addr   = 32'h40;
    bus3.req_wdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus3.req_we     = 1'b0;
    @(negedge clk);
    bus3.req_valid  = 1'b0;
    rst3 = 1'b1;
    #1;
    checks++;
    if (bus3.req_ready !== 1'b0 || bus3.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat3_in_reset got ready=%b valid=%b want 0/0", bus3.req_ready,
               bus3.rsp_valid);
    end
    @(negedge clk);
    rst3 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus3.rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL lat3_dropped_c%0d got %b want 0", c, bus3.rsp_valid);
      end
    end
    bus3.req_valid  = 1'b1;
    bus3.req_we     = 1'b0;
    bus3.req_addr   = 32'h40;
    @(negedge clk);
    bus3.req_valid  = 1'b0;
    n = 0;
    while (bus3.rsp_valid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL lat3_relw_latency got %0d want 2", n);
    end
    checks++;
    if (rsp3() !== {3'b100, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL lat3_relw_data got %h want %h", rsp3(), {3'b100, 32'hDEAD_BEEF});
    end
  endtask

  initial begin
    rst1 = 1'b1;
    rst3 = 1'b1;
    bus1.req_valid  = 1'b0;
    bus1.req_we     = 1'b0;
    bus1.req_funct3 = 3'b000;
    bus1.req_addr   = 32'h0;
    bus1.req_wdata  = 32'h0;
    bus3.req_valid  = 1'b0;
    bus3.req_we     = 1'b0;
    bus3.req_funct3 = 3'b000;
    bus3.req_addr   = 32'h0;
    bus3.req_wdata  = 32'h0;

    test_reset();
    test_lw();
    test_byte();
    test_half();
    test_faults();
    test_back_to_back();
    test_lat3_burst();
    test_lat3_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
